toggle_pulse_decoder: RTL and testbench

- Receive end of a toggle-encoded event link. The sender flips a T flip-flop once per event; this block recovers one pulse per flip.
- Synchronises the asynchronous toggle level and detects each level change as one event.
- Buffers events as a saturating pending count, drained through a valid/ready handshake.
- Sits in the destination clock domain at the boundary of any T-flip-flop-driven event channel.

---
 rtl/toggle_pulse_decoder.sv | 161 ++++++++++++++++
 tb/tb_toggle_pulse_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_decoder.sv
// toggle_pulse_decoder
// Receive side of a toggle-encoded event link. The remote T flip-flop level is
// synchronised into clk. Each level change becomes one pulse_out, and each
// detected event is held in a saturating pending counter. A valid/ready
// handshake drains that counter.
// Optional build macro TDEC_TOTAL_CNT_EN adds a 16-bit wrapping total_cnt output.
//
// state | meaning
// INIT  | baseline settling after reset, no event detection, busy_init = 1
// RUN   | compare synchronised level to baseline, one event per change

module toggle_pulse_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    input  logic             clr_ovf,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             pulse_out,
    output logic             q_mirror,
    output logic             overflow,
`ifdef TDEC_TOTAL_CNT_EN
    output logic [15:0]      total_cnt,
`endif
    output logic             busy_init
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int IW = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;
    localparam logic [IW-1:0]    INIT_LAST = IW'(SYNC_STAGES - 1);
    localparam logic [IW-1:0]    INIT_ONE  = IW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [IW-1:0]            init_q, init_d;
    logic                     base_q, base_d;
    logic                     mirror_q, mirror_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     pulse_q, pulse_d;
    logic                     busy_q, busy_d;
    logic                     sync_out;
    logic                     evt_det;
    logic                     hs;
`ifdef TDEC_TOTAL_CNT_EN
    logic [15:0]              total_q, total_d;
`endif

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign evt_valid = (cnt_q != '0);
    assign hs        = evt_valid & evt_ready;

    assign pend_cnt  = cnt_q;
    assign pulse_out = pulse_q;
    assign q_mirror  = mirror_q;
    assign overflow  = ovf_q;
    assign busy_init = busy_q;
`ifdef TDEC_TOTAL_CNT_EN
    assign total_cnt = total_q;
`endif

    // State register, synchroniser and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            sync_q   <= '0;
            init_q   <= '0;
            base_q   <= 1'b0;
            mirror_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef TDEC_TOTAL_CNT_EN
            total_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            init_q   <= init_d;
            base_q   <= base_d;
            mirror_q <= mirror_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
`ifdef TDEC_TOTAL_CNT_EN
            total_q  <= total_d;
`endif
        end
    end

    // Next-state, event detection, pending counter and overflow logic
    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[SYNC_STAGES-2:0], tog_in};
        init_d   = init_q;
        base_d   = base_q;
        mirror_d = mirror_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        evt_det  = 1'b0;

        case (state_q)
            ST_INIT: begin
                init_d = init_q + INIT_ONE;
                if (init_q == INIT_LAST) begin
                    // Take the level that lands on sync_out at this edge, so
                    // the first RUN compare sees baseline == sync_out.
                    base_d   = sync_q[SYNC_STAGES-2];
                    mirror_d = sync_q[SYNC_STAGES-2];
                    init_d   = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sync_out != base_q) begin
                    evt_det  = 1'b1;
                    base_d   = sync_out;
                    mirror_d = sync_out;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (evt_det && !hs) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!evt_det && hs) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        // A new drop on the clearing edge wins over the clear
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (evt_det && !hs && (cnt_q == CNT_MAX)) begin
            ovf_d = 1'b1;
        end

        pulse_d = evt_det;
        busy_d  = (state_d == ST_INIT);
`ifdef TDEC_TOTAL_CNT_EN
        total_d = evt_det ? total_q + 16'd1 : total_q;
`endif
    end

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Directed test of toggle_pulse_decoder with SYNC_STAGES = 2 and CNT_W = 4.
module tb_toggle_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       tog_in;
    logic       clr_ovf;
    logic       evt_ready;
    logic       evt_valid;
    logic [3:0] pend_cnt;
    logic       pulse_out;
    logic       q_mirror;
    logic       overflow;
    logic       busy_init;
`ifdef TDEC_TOTAL_CNT_EN
    logic [15:0] total_cnt;
    int          ev_cnt = 0;
`endif

    int total = 0;
    int bad   = 0;

    toggle_pulse_decoder #(.SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .clr_ovf   (clr_ovf),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .pend_cnt  (pend_cnt),
        .pulse_out (pulse_out),
        .q_mirror  (q_mirror),
        .overflow  (overflow),
`ifdef TDEC_TOTAL_CNT_EN
        .total_cnt (total_cnt),
`endif
        .busy_init (busy_init)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Flip the toggle, expect a pulse after the third edge, then pad to 5 cycles.
    task automatic toggle_evt(input string tag);
        tog_in = ~tog_in;
        tick();
        tick();
        tick();
        check(tag, int'(pulse_out), 1);
`ifdef TDEC_TOTAL_CNT_EN
        ev_cnt++;
`endif
        tick();
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        tog_in    = 1'b1;
        clr_ovf   = 1'b0;
        evt_ready = 1'b0;
        tick();
        tick();
        check("rst_busy",     int'(busy_init), 1);
        check("rst_pend",     int'(pend_cnt),  0);
        check("rst_valid",    int'(evt_valid), 0);
        check("rst_pulse",    int'(pulse_out), 0);
        check("rst_mirror",   int'(q_mirror),  0);
        check("rst_ovf",      int'(overflow),  0);
`ifdef TDEC_TOTAL_CNT_EN
        check("rst_total",    int'(total_cnt), 0);
`endif

        // release with tog_in = 1: two INIT cycles, baseline = 1, no event
        rst = 1'b1;
        tick();
        check("init1_busy",   int'(busy_init), 1);
        check("init1_pulse",  int'(pulse_out), 0);
        tick();
        check("init2_busy",   int'(busy_init), 0);
        check("init2_mirror", int'(q_mirror),  1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("init_nopulse", int'(pulse_out), 0);
            check("init_nopend",  int'(pend_cnt),  0);
        end

        // latency: change sampled at edge N, pulse after edge N+2
        tog_in = 1'b0;
        tick();
        check("lat_n0_pulse", int'(pulse_out), 0);
        tick();
        check("lat_n1_pulse", int'(pulse_out), 0);
        check("lat_n1_pend",  int'(pend_cnt),  0);
        tick();
        check("lat_n2_pulse", int'(pulse_out), 1);
        check("lat_n2_pend",  int'(pend_cnt),  1);
        check("lat_n2_valid", int'(evt_valid), 1);
        check("lat_n2_mirror", int'(q_mirror), 0);
        tick();
        check("lat_n3_pulse", int'(pulse_out), 0);
`ifdef TDEC_TOTAL_CNT_EN
        ev_cnt++;
`endif
        tick();
        toggle_evt("lat_rise_pulse");
        check("lat_rise_mirror", int'(q_mirror), 1);
        check("lat_rise_pend",   int'(pend_cnt), 2);

        // drain, including ready with nothing pending
        evt_ready = 1'b1;
        tick();
        check("drain_pend1",  int'(pend_cnt),  1);
        tick();
        check("drain_pend0",  int'(pend_cnt),  0);
        check("drain_valid0", int'(evt_valid), 0);
        tick();
        check("underflow",    int'(pend_cnt),  0);
        evt_ready = 1'b0;

        // three events queued, then drained on consecutive edges
        for (int i = 0; i < 3; i++) begin
            toggle_evt("q3_pulse");
            check("q3_pend", int'(pend_cnt), i + 1);
        end
        evt_ready = 1'b1;
        tick();
        check("q3_drain2", int'(pend_cnt), 2);
        tick();
        check("q3_drain1", int'(pend_cnt), 1);
        check("q3_valid1", int'(evt_valid), 1);
        tick();
        check("q3_drain0", int'(pend_cnt), 0);
        check("q3_valid0", int'(evt_valid), 0);
        evt_ready = 1'b0;

        // saturation: 16 events, overflow on the 16th
        for (int i = 0; i < 16; i++) begin
            toggle_evt("sat_pulse");
            check("sat_pend", int'(pend_cnt), (i < 15) ? i + 1 : 15);
            check("sat_ovf",  int'(overflow), (i < 15) ? 0 : 1);
        end
        tick();
        check("ovf_sticky", int'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr",      int'(overflow), 0);
        check("ovf_clr_pend", int'(pend_cnt), 15);

        // drain to 2, then event and handshake on the same edge
        evt_ready = 1'b1;
        repeat (13) tick();
        evt_ready = 1'b0;
        check("pre_sim_pend", int'(pend_cnt), 2);
        tog_in = ~tog_in;
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("sim_pulse", int'(pulse_out), 1);
        check("sim_pend",  int'(pend_cnt),  2);
        check("sim_ovf",   int'(overflow),  0);
`ifdef TDEC_TOTAL_CNT_EN
        ev_cnt++;
`endif
        tick();
        tick();

        // refill to 15, then a drop on the same edge as clr_ovf
        for (int i = 0; i < 13; i++) begin
            toggle_evt("fill_pulse");
        end
        check("fill_pend", int'(pend_cnt), 15);
        check("fill_ovf",  int'(overflow), 0);
        tog_in = ~tog_in;
        tick();
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("setwins_ovf",  int'(overflow), 1);
        check("setwins_pend", int'(pend_cnt), 15);
`ifdef TDEC_TOTAL_CNT_EN
        ev_cnt++;
`endif
        tick();
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("setwins_clr", int'(overflow), 0);

        // event plus handshake at full count: no overflow
        tog_in = ~tog_in;
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("satsim_pulse", int'(pulse_out), 1);
        check("satsim_pend",  int'(pend_cnt),  15);
        check("satsim_ovf",   int'(overflow),  0);
`ifdef TDEC_TOTAL_CNT_EN
        ev_cnt++;
`endif
        tick();
        tick();
`ifdef TDEC_TOTAL_CNT_EN
        check("total_cnt", int'(total_cnt), ev_cnt);
`endif

        // drain to 5, then reset with a toggle in the synchroniser
        evt_ready = 1'b1;
        repeat (10) tick();
        evt_ready = 1'b0;
        check("pre_rst_pend", int'(pend_cnt), 5);
        tog_in = ~tog_in;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_pend",   int'(pend_cnt),  0);
        check("midrst_valid",  int'(evt_valid), 0);
        check("midrst_busy",   int'(busy_init), 1);
        check("midrst_mirror", int'(q_mirror),  0);
`ifdef TDEC_TOTAL_CNT_EN
        check("midrst_total",  int'(total_cnt), 0);
`endif
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("postrst_pulse", int'(pulse_out), 0);
            check("postrst_pend",  int'(pend_cnt),  0);
        end
        check("postrst_busy",   int'(busy_init), 0);
        check("postrst_mirror", int'(q_mirror),  int'(tog_in));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
